// File: rtl/str_slot_sched.sv
// Overlay string-slot scheduler: round-robin arbitration, serial binary-to-BCD conversion,
// shadow/active descriptor tables committed on vsync. Optional STR_SCHED_ZERO_BLANK_EN blanks leading zeros.
module str_slot_sched #(
  parameter int N_REQ = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_vsync,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*4-1:0]   i_req_slot,
  input  logic [N_REQ*8-1:0]   i_req_val,
  input  logic [N_REQ*19-1:0]  i_req_attr,
  output logic [N_REQ-1:0]     o_gnt,
  output logic                 o_busy,
  output logic [16*64-1:0]     o_str
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [63:0] RESET_ENTRY = {13'b0, 3'b111, 8'd0, 8'd0, 32'h20202020};

  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg;
  logic [PW-1:0]     ptr_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic [3:0]        slot_reg;
  logic [7:0]        val_reg;
  logic [18:0]       attr_reg;
  logic [1:0]        hun_reg;
  logic [3:0]        ten_reg, one_reg;
  logic              vsync_d_reg;
  logic [63:0]       shadow_reg [16];
  logic [63:0]       active_reg [16];

  // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest.
  logic [N_REQ-1:0]  upper_mask, req_hi;
  logic              grant_found;
  logic [PW-1:0]     grant_idx;
  logic [3:0]        sel_slot;
  logic [7:0]        sel_val;
  logic [18:0]       sel_attr;

  always_comb begin
    upper_mask  = ~((N_REQ'(1) << ptr_reg) - N_REQ'(1));
    req_hi      = i_req & upper_mask;
    grant_found = |i_req;
    grant_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) grant_idx = PW'(j);
    end
    if (|req_hi) begin
      for (int j = N_REQ - 1; j >= 0; j--) begin
        if (req_hi[j]) grant_idx = PW'(j);
      end
    end
    sel_slot = '0;
    sel_val  = '0;
    sel_attr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant_idx == PW'(j)) begin
        sel_slot = i_req_slot[j*4 +: 4];
        sel_val  = i_req_val[j*8 +: 8];
        sel_attr = i_req_attr[j*19 +: 19];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = CONV;
      CONV:    if (cnt_reg == 3'd7) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction applied before each left shift.
  logic [3:0] ten_adj, one_adj;
  assign ten_adj = (ten_reg >= 4'd5) ? ten_reg + 4'd3 : ten_reg;
  assign one_adj = (one_reg >= 4'd5) ? one_reg + 4'd3 : one_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_reg  <= '0;
      ptr_reg  <= '0;
      gnt_reg  <= '0;
      slot_reg <= '0;
      val_reg  <= '0;
      attr_reg <= '0;
      hun_reg  <= '0;
      ten_reg  <= '0;
      one_reg  <= '0;
    end else begin
      gnt_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            gnt_reg  <= N_REQ'(1) << grant_idx;
            ptr_reg  <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
            slot_reg <= sel_slot;
            val_reg  <= sel_val;
            attr_reg <= sel_attr;
            hun_reg  <= '0;
            ten_reg  <= '0;
            one_reg  <= '0;
            cnt_reg  <= '0;
          end
        end
        CONV: begin
          {hun_reg, ten_reg, one_reg, val_reg} <= {hun_reg[0], ten_adj, one_adj, val_reg, 1'b0};
          cnt_reg <= cnt_reg + 3'd1;
        end
        default: ;
      endcase
    end
  end

  logic [7:0] hun_chr, ten_chr, one_chr;
  always_comb begin
    hun_chr = 8'd48 + {6'd0, hun_reg};
    ten_chr = 8'd48 + {4'd0, ten_reg};
    one_chr = 8'd48 + {4'd0, one_reg};
`ifdef STR_SCHED_ZERO_BLANK_EN
    if (hun_reg == 2'd0) hun_chr = 8'h20;
    if (hun_reg == 2'd0 && ten_reg == 4'd0) ten_chr = 8'h20;
`endif
  end

  // Nonblocking semantics make a same-cycle commit copy the pre-write shadow.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d_reg <= 1'b0;
      for (int s = 0; s < 16; s++) begin
        shadow_reg[s] <= RESET_ENTRY;
        active_reg[s] <= RESET_ENTRY;
      end
    end else begin
      vsync_d_reg <= i_vsync;
      if (state_reg == WRITE)
        shadow_reg[slot_reg] <= {13'b0, attr_reg, 8'h20, hun_chr, ten_chr, one_chr};
      if (i_vsync && !vsync_d_reg) begin
        for (int s = 0; s < 16; s++) active_reg[s] <= shadow_reg[s];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_out
      assign o_str[gi*64 +: 64] = active_reg[gi];
    end
  endgenerate

  assign o_gnt  = gnt_reg;
  assign o_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_str_slot_sched.sv
// Directed bench for str_slot_sched (N_REQ = 4); expectations follow STR_SCHED_ZERO_BLANK_EN when defined.
module tb_str_slot_sched;

  localparam int N = 4;
  localparam logic [63:0] RST_E = 64'h0007_0000_2020_2020;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             i_vsync;
  logic [N-1:0]     i_req;
  logic [N*4-1:0]   i_req_slot;
  logic [N*8-1:0]   i_req_val;
  logic [N*19-1:0]  i_req_attr;
  logic [N-1:0]     o_gnt;
  logic             o_busy;
  logic [16*64-1:0] o_str;

  int tests_run = 0;
  int tests_failed = 0;

  str_slot_sched #(.N_REQ(N)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_vsync(i_vsync),
    .i_req(i_req), .i_req_slot(i_req_slot), .i_req_val(i_req_val), .i_req_attr(i_req_attr),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_str(o_str)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [63:0] slot_of(input int s);
    return o_str[s*64 +: 64];
  endfunction

  // Stimulus only: one request on requester k; returns the grant seen one cycle later.
  task automatic do_req(input int k, input logic [3:0] slot, input logic [7:0] val,
                        input logic [18:0] attr, output logic [N-1:0] gnt_seen);
    i_req_slot[k*4 +: 4]   = slot;
    i_req_val[k*8 +: 8]    = val;
    i_req_attr[k*19 +: 19] = attr;
    i_req[k] = 1'b1;
    @(negedge sys_clk);
    gnt_seen = o_gnt;
    i_req[k] = 1'b0;
    repeat (9) @(negedge sys_clk);
    $display("[TB] req%0d slot=%0d val=%0d gnt=%b", k, slot, val, gnt_seen);
  endtask

  task automatic pulse_vsync();
    i_vsync = 1'b1;
    @(negedge sys_clk);
    i_vsync = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    int bad;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    bad = 0;
    for (int s = 0; s < 16; s++) if (slot_of(s) !== RST_E) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL reset_table: %0d entries wrong, want %h", bad, RST_E); end
    tests_run++;
    if (o_gnt !== 4'b0 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: gnt=%b busy=%b, want 0000 0", o_gnt, o_busy);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_request();
    int bad;
    logic [N-1:0] g;
    i_req_slot[3:0]  = 4'd3;
    i_req_val[7:0]   = 8'd255;
    i_req_attr[18:0] = {3'b011, 8'd150, 8'd135};
    i_req[0] = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if (o_gnt !== 4'b0001 || o_busy !== 1'b1) begin
      tests_failed++; $display("FAIL req_grant: gnt=%b busy=%b, want 0001 1", o_gnt, o_busy);
    end
    i_req[0] = 1'b0;
    bad = 0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge sys_clk);
      if (o_busy !== 1'b1 || o_gnt !== 4'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL req_busy_window: %0d cycles wrong, want 0", bad); end
    @(negedge sys_clk);
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL req_busy_end: busy=%b, want 0", o_busy); end
    tests_run++;
    if (slot_of(3) !== RST_E) begin
      tests_failed++; $display("FAIL req_no_commit: slot3=%h, want %h", slot_of(3), RST_E);
    end
    i_vsync = 1'b1;
    @(negedge sys_clk);
    tests_run++;
    if (slot_of(3) !== 64'h0003_9687_2032_3535) begin
      tests_failed++; $display("FAIL req_commit: slot3=%h, want 0003968720323535", slot_of(3));
    end
    // vsync stays high: a later write must not be committed
    do_req(0, 4'd3, 8'd100, {3'b011, 8'd150, 8'd135}, g);
    tests_run++;
    if (g !== 4'b0001) begin tests_failed++; $display("FAIL held_grant: gnt=%b, want 0001", g); end
    tests_run++;
    if (slot_of(3) !== 64'h0003_9687_2032_3535) begin
      tests_failed++; $display("FAIL vsync_held: slot3=%h, want 0003968720323535", slot_of(3));
    end
    i_vsync = 1'b0;
    @(negedge sys_clk);
    pulse_vsync();
    tests_run++;
    if (slot_of(3) !== 64'h0003_9687_2031_3030) begin
      tests_failed++; $display("FAIL vsync_rearm: slot3=%h, want 0003968720313030", slot_of(3));
    end
  endtask

  task automatic test_round_robin();
    int c;
    logic [N-1:0] want;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      i_req_slot[k*4 +: 4]   = 4'(k);
      i_req_val[k*8 +: 8]    = 8'(10 + k);
      i_req_attr[k*19 +: 19] = '0;
    end
    i_req = 4'b1111;
    @(negedge sys_clk);
    tests_run++;
    if (o_gnt !== 4'b0001) begin tests_failed++; $display("FAIL rr_first: gnt=%b, want 0001", o_gnt); end
    for (int g = 1; g <= 4; g++) begin
      want = 4'b0001 << (g % 4);
      c = 0;
      do begin
        @(negedge sys_clk);
        c++;
      end while (o_gnt === 4'b0 && c < 20);
      tests_run++;
      if (o_gnt !== want || c != 10) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: gnt=%b after %0d cycles, want %b after 10", g, o_gnt, c, want);
      end
      $display("[TB] rr grant %0d gnt=%b spacing=%0d", g, o_gnt, c);
    end
    i_req = '0;
    c = 0;
    while (o_busy !== 1'b0 && c < 20) begin @(negedge sys_clk); c++; end
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL rr_drain: busy=%b, want 0", o_busy); end
  endtask

  task automatic test_commit_collision();
    logic [63:0] exp;
`ifdef STR_SCHED_ZERO_BLANK_EN
    exp = 64'h0001_0A14_2020_3432;
`else
    exp = 64'h0001_0A14_2030_3432;
`endif
    i_req_slot[3:0]  = 4'd5;
    i_req_val[7:0]   = 8'd42;
    i_req_attr[18:0] = {3'b001, 8'd10, 8'd20};
    i_req[0] = 1'b1;
    @(negedge sys_clk);
    i_req[0] = 1'b0;
    repeat (8) @(negedge sys_clk);
    i_vsync = 1'b1;            // edge lands in the WRITE cycle
    @(negedge sys_clk);
    tests_run++;
    if (slot_of(5) !== RST_E) begin
      tests_failed++; $display("FAIL collision_old: slot5=%h, want %h", slot_of(5), RST_E);
    end
    i_vsync = 1'b0;
    @(negedge sys_clk);
    pulse_vsync();
    tests_run++;
    if (slot_of(5) !== exp) begin
      tests_failed++; $display("FAIL collision_next: slot5=%h, want %h", slot_of(5), exp);
    end
  endtask

  task automatic test_zero_blank();
    logic [N-1:0] g;
    logic [63:0] e6, e7, e8;
`ifdef STR_SCHED_ZERO_BLANK_EN
    e6 = 64'h2020_2037; e7 = 64'h2020_2030;
`else
    e6 = 64'h2030_3037; e7 = 64'h2030_3030;
`endif
    e8 = 64'h2031_3030;
    do_req(1, 4'd6, 8'd7, '0, g);
    tests_run++;
    if (g !== 4'b0010) begin tests_failed++; $display("FAIL blank_grant: gnt=%b, want 0010", g); end
    do_req(1, 4'd7, 8'd0, '0, g);
    do_req(1, 4'd8, 8'd100, '0, g);
    pulse_vsync();
    tests_run++;
    if (slot_of(6) !== e6) begin tests_failed++; $display("FAIL blank_7: slot6=%h, want %h", slot_of(6), e6); end
    tests_run++;
    if (slot_of(7) !== e7) begin tests_failed++; $display("FAIL blank_0: slot7=%h, want %h", slot_of(7), e7); end
    tests_run++;
    if (slot_of(8) !== e8) begin tests_failed++; $display("FAIL blank_100: slot8=%h, want %h", slot_of(8), e8); end
  endtask

  task automatic test_mid_reset();
    int bad;
    i_req_slot[3:0]  = 4'd9;
    i_req_val[7:0]   = 8'd200;
    i_req_attr[18:0] = {3'b010, 8'd1, 8'd2};
    i_req[0] = 1'b1;
    @(negedge sys_clk);
    i_req[0] = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    bad = 0;
    for (int s = 0; s < 16; s++) if (slot_of(s) !== RST_E) bad++;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL midrst_table: %0d entries wrong, want 0", bad); end
    tests_run++;
    if (o_busy !== 1'b0 || o_gnt !== 4'b0) begin
      tests_failed++; $display("FAIL midrst_ctrl: busy=%b gnt=%b, want 0 0000", o_busy, o_gnt);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12) @(negedge sys_clk);
    pulse_vsync();
    tests_run++;
    if (slot_of(9) !== RST_E) begin
      tests_failed++; $display("FAIL midrst_nowrite: slot9=%h, want %h", slot_of(9), RST_E);
    end
    i_req = 4'b0101;
    @(negedge sys_clk);
    tests_run++;
    if (o_gnt !== 4'b0001) begin tests_failed++; $display("FAIL midrst_prio: gnt=%b, want 0001", o_gnt); end
    i_req = 4'b0100;
    repeat (10) @(negedge sys_clk);
    tests_run++;
    if (o_gnt !== 4'b0100) begin tests_failed++; $display("FAIL midrst_next: gnt=%b, want 0100", o_gnt); end
    i_req = '0;
    repeat (10) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    i_vsync    = 1'b0;
    i_req      = '0;
    i_req_slot = '0;
    i_req_val  = '0;
    i_req_attr = '0;
    test_reset();
    test_request();
    test_round_robin();
    test_commit_collision();
    test_zero_blank();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
